// File: rtl/hs4_pkg.sv
// Shared types and defaults for the 4-phase req/ack transmit master.
package hs4_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StReqHi = 3'd2,
        StReqLo = 3'd3,
        StErr   = 3'd4
    } state_e;

    localparam int unsigned DefDataW      = 8;
    localparam int unsigned DefFifoDepth  = 4;
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefTimeoutCyc = 255;
    localparam int unsigned DefCntW       = 16;

    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/hs4_sync_fifo.sv
// Synchronous FIFO with a combinational head word; pointers carry one wrap bit.
module hs4_sync_fifo
    import hs4_pkg::*;
#(
    parameter int unsigned WIDTH = DefDataW + 1,
    parameter int unsigned DEPTH = DefFifoDepth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[PW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr_q[PW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/hs4_master_tx.sv
// 4-phase req/ack transmit master: buffers upstream words and sends each one over a
// full handshake with a synchronised ack, per-phase timeout and burst-done pulse.
module hs4_master_tx
    import hs4_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              req,
    output logic [DATA_W-1:0] data,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [DATA_W:0]        head;
    state_e                 state_q;
    logic                   last_q;
    logic [TW-1:0]          tmo_q;
    logic                   tmo_hit;

    assign ack_s    = ack_sync_q[SYNC_STAGES-1];
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == StIdle) && !empty;
    assign busy     = (state_q != StIdle) || !empty;
    // Fires on the TIMEOUT_CYC-th cycle spent in a wait phase.
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC - 1));

    hs4_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_last, in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_q  <= '0;
            state_q     <= StIdle;
            req         <= 1'b0;
            data        <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            word_count  <= '0;
            last_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
            done       <= 1'b0;
            // A timeout in the same cycle overrides this clear further down.
            if (err_clr) timeout_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    req <= 1'b0;
                    if (!empty) begin
                        data    <= head[DATA_W-1:0];
                        last_q  <= head[DATA_W];
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    req     <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= StReqHi;
                end
                StReqHi: begin
                    if (ack_s) begin
                        req     <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= StReqLo;
                    end else if (tmo_hit) begin
                        req         <= 1'b0;
                        timeout_err <= 1'b1;
                        state_q     <= StErr;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StReqLo: begin
                    req <= 1'b0;
                    if (!ack_s) begin
                        word_count <= word_count + 1'b1;
                        done       <= last_q;
                        state_q    <= StIdle;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state_q     <= StErr;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StErr: begin
                    req <= 1'b0;
                    if (!ack_s) state_q <= StIdle;
                end
                default: begin
                    req     <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
